ex_div: RTL and testbench

//  Iterative radix-2 RV64M divider in the EX stage, directly downstream of the ID/EX pipeline register.

---
 rtl/ex_div.sv | 119 +++++++++++
 tb/tb_ex_div.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Holds the front end via hold_flag_o while iterating; emits a one-cycle result strobe.
module ex_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o,
  output logic [4:0]      rd_addr_o,
  output logic            busy_o,
  output logic            hold_flag_o
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_result;
  logic [4:0]      r_rd;
  logic            r_word, r_rsel, r_negq, r_negr;

  function automatic logic [XLEN-1:0] fmt_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Effective operands: W forms see the low word, sign- or zero-extended.
  logic            w_signed, w_div0, w_ovf, w_a_neg, w_b_neg, w_go;
  logic [XLEN-1:0] w_a_eff, w_b_eff, w_a_abs, w_b_abs, w_spec_raw;
  assign w_signed = ~op_i[0];
  assign w_a_eff  = word_i ? {{(XLEN-32){w_signed & dividend_i[31]}}, dividend_i[31:0]} : dividend_i;
  assign w_b_eff  = word_i ? {{(XLEN-32){w_signed & divisor_i[31]}}, divisor_i[31:0]} : divisor_i;
  assign w_div0   = (w_b_eff == '0);
  assign w_ovf    = w_signed & (word_i ?
                    (dividend_i[31:0] == 32'h8000_0000 && divisor_i[31:0] == 32'hFFFF_FFFF) :
                    (dividend_i == {1'b1, {(XLEN-1){1'b0}}} && divisor_i == '1));
  assign w_a_neg  = w_signed & w_a_eff[XLEN-1];
  assign w_b_neg  = w_signed & w_b_eff[XLEN-1];
  assign w_a_abs  = w_a_neg ? -w_a_eff : w_a_eff;
  assign w_b_abs  = w_b_neg ? -w_b_eff : w_b_eff;
  assign w_spec_raw = op_i[1] ? (w_div0 ? w_a_eff : '0) : (w_div0 ? '1 : w_a_eff);
  assign w_go     = (r_state == S_IDLE) & start_i & op_i[2] & ~flush_i;

  // One restoring step: the extra top bit of the difference is the borrow.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_q_mag, w_r_mag, w_q_fin, w_r_fin, w_calc_res;
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = ~w_diff[XLEN];
  assign w_rem_nxt  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
  assign w_q_mag    = r_word ? {{(XLEN-32){1'b0}}, w_quo_nxt[31:0]} : w_quo_nxt;
  assign w_r_mag    = r_word ? {{(XLEN-32){1'b0}}, w_rem_nxt[31:0]} : w_rem_nxt;
  assign w_q_fin    = r_negq ? -w_q_mag : w_q_mag;
  assign w_r_fin    = r_negr ? -w_r_mag : w_r_mag;
  assign w_calc_res = fmt_w(r_word, r_rsel ? w_r_fin : w_q_fin);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = (w_div0 | w_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (flush_i) w_state_nxt = S_IDLE;
               else if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_rd     <= '0;
      r_word   <= 1'b0;
      r_rsel   <= 1'b0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_rd   <= rd_addr_i;
        r_word <= word_i;
        r_rsel <= op_i[1];
        r_negq <= w_a_neg ^ w_b_neg;
        r_negr <= w_a_neg;
        r_rem  <= '0;
        // W forms park the 32-bit dividend at the top so it shifts out first.
        r_quo  <= word_i ? {w_a_abs[31:0], {(XLEN-32){1'b0}}} : w_a_abs;
        r_div  <= word_i ? {{(XLEN-32){1'b0}}, w_b_abs[31:0]} : w_b_abs;
        r_cnt  <= word_i ? CW'(32) : CW'(XLEN);
        if (w_div0 | w_ovf) r_result <= fmt_w(word_i, w_spec_raw);
      end else if (r_state == S_CALC && !flush_i) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) r_result <= w_calc_res;
      end
    end
  end

  assign result_o       = r_result;
  assign rd_addr_o      = r_rd;
  assign result_valid_o = (r_state == S_DONE) & ~flush_i;
  assign busy_o         = (r_state == S_CALC) | (r_state == S_DONE);
  assign hold_flag_o    = w_go | (r_state == S_CALC);
endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: directed RV64M corner cases plus random ops
// checked against an arithmetic reference model.
module tb_ex_div;
  logic        clk = 1'b0;
  logic        rst, start_i, word_i, flush_i;
  logic [2:0]  op_i;
  logic [63:0] dividend_i, divisor_i, result_o;
  logic [4:0]  rd_addr_i, rd_addr_o;
  logic        result_valid_o, busy_o, hold_flag_o;

  ex_div #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .word_i(word_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .result_o(result_o), .result_valid_o(result_valid_o),
    .rd_addr_o(rd_addr_o), .busy_o(busy_o), .hold_flag_o(hold_flag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          lat;
    int          e;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0, nerr = 0, cyc = 0, hold_tot = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: RISC-V division rules expressed with plain SV arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, x32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 0) begin q32 = '1; r32 = a32; end
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
      else if (!op[0]) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      x32 = op[1] ? r32 : q32;
      return {{32{x32[31]}}, x32};
    end
    if (b == 0) begin q = ONES; r = a; end
    else if (!op[0] && a == MIN64 && b == ONES) begin q = a; r = 0; end
    else if (!op[0]) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    if (b == 0 || (!op[0] && a == MIN64 && b == ONES)) return 1;
    return 65;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = 64'd0;
      1: v = ONES;
      2: v = MIN64;
      3: v = {$urandom(), 32'h8000_0000};
      4: v = {32'd0, $urandom()};
      5: begin v = 64'($urandom_range(1, 20)); if ($urandom_range(0, 1) == 1) v = -v; end
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops one expectation per strobe; a strobe with nothing pending is an error.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (hold_flag_o) hold_tot++;
    if (result_valid_o) begin
      if (sb.size() == 0) begin
        ncmp++;
        nerr++;
        $display("FAIL unexpected_strobe got=%h rd=%0d exp=none", result_o, rd_addr_o);
      end else begin
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd_addr", 64'(rd_addr_o), 64'(e.rd));
        chk("latency", 64'(cyc - e.e + 1), 64'(e.lat));
      end
    end
  end

  // Called at posedge+1; start is sampled on the next posedge.
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input logic expect_it,
                       input logic [63:0] exp, input int lat);
    exp_t t;
    start_i = 1'b1; op_i = op; word_i = w;
    dividend_i = a; divisor_i = b; rd_addr_i = rd;
    if (expect_it) begin
      t.res = exp; t.rd = rd; t.lat = lat; t.e = cyc + 1;
      sb.push_back(t);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    dividend_i = {$urandom(), $urandom()};
    divisor_i  = {$urandom(), $urandom()};
    rd_addr_i  = 5'($urandom());
  endtask

  task automatic wait_done();
    for (int i = 0; i < 150 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL timeout got=%0d_pending exp=0_pending", sb.size());
      sb.delete();
    end
    #1;
  endtask

  task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    issue(op, w, a, b, 5'($urandom_range(1, 31)), 1'b1, exp, lat);
    wait_done();
  endtask

  initial begin
    int h0;
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; word_i = 1'b0; op_i = 3'b000;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result_o, 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_rd", 64'(rd_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_hold", 64'(hold_flag_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    h0 = hold_tot;
    run(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    chk("divu_hold_cycles", 64'(hold_tot - h0), 64'd65);
    chk("idle_busy", 64'(busy_o), 64'd0);

    run(3'b100, 1'b0, -64'd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run(3'b110, 1'b0, -64'd7, 64'd2, ONES, 65);
    run(3'b110, 1'b0, 64'd7, -64'd2, 64'd1, 65);

    run(3'b101, 1'b0, 64'd5, 64'd0, ONES, 1);
    run(3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    run(3'b100, 1'b1, 64'd5, 64'd0, ONES, 1);

    run(3'b100, 1'b0, MIN64, ONES, MIN64, 1);
    run(3'b110, 1'b0, MIN64, ONES, 64'd0, 1);
    run(3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);

    run(3'b101, 1'b1, 64'h1_FFFF_FFFF, 64'd1, ONES, 33);
    run(3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 33);

    // Flush in CALC cycle 10: no strobe may follow.
    issue(3'b101, 1'b0, 64'd1000, 64'd3, 5'd9, 1'b0, 64'd0, 0);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_calc_busy", 64'(busy_o), 64'd0);
    repeat (80) @(posedge clk);
    #1;

    // Flush landing on the DONE cycle suppresses the strobe.
    issue(3'b101, 1'b0, 64'd5, 64'd0, 5'd4, 1'b0, 64'd0, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_done_busy", 64'(busy_o), 64'd0);

    // Flush with start in IDLE: nothing starts.
    start_i = 1'b1; op_i = 3'b100; word_i = 1'b0;
    dividend_i = 64'd50; divisor_i = 64'd5; flush_i = 1'b1;
    #1;
    chk("flush_start_hold", 64'(hold_flag_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 64'(busy_o), 64'd0);
    repeat (70) @(posedge clk);
    #1;

    // Reset in the middle of CALC.
    issue(3'b100, 1'b0, 64'd12345, 64'd11, 5'd17, 1'b0, 64'd0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_calc_result", result_o, 64'd0);
    chk("rst_calc_valid", 64'(result_valid_o), 64'd0);
    chk("rst_calc_rd", 64'(rd_addr_o), 64'd0);
    chk("rst_calc_busy", 64'(busy_o), 64'd0);
    chk("rst_calc_hold", 64'(hold_flag_o), 64'd0);
    rst = 1'b0;
    repeat (70) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      rop = 3'(3'b100 | 3'($urandom_range(0, 3)));
      rw  = 1'($urandom_range(0, 1));
      ra  = pick();
      rb  = pick();
      run(rop, rw, ra, rb, ref_model(rop, rw, ra, rb), ref_lat(rop, rw, ra, rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
